// File: rtl/vec_arb_pkg.sv
// Shared types and constants for the vector operand mux arbiter.
// Provides FSM state enum, select encodings and a one-hot helper.
package vec_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  localparam int NREQ = 3;

  localparam logic [1:0] SEL_D0 = 2'b00;
  localparam logic [1:0] SEL_D1 = 2'b01;
  localparam logic [1:0] SEL_D2 = 2'b10;

  function automatic logic [2:0] onehot3(input logic [1:0] sel);
    logic [2:0] oh;
    oh = 3'b000;
    case (sel)
      SEL_D0:  oh = 3'b001;
      SEL_D1:  oh = 3'b010;
      SEL_D2:  oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/vec_mux_arbiter_rr_pick3.sv
// Combinational round-robin picker over three requests.
// Ports: i_req[2:0], i_ptr[1:0] -> o_idx[1:0] first set bit from ptr, o_found.
module rr_pick3
  import vec_arb_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [1:0] o_idx,
  output logic       o_found
);

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic [1:0] w_c0;
  logic [1:0] w_c1;
  logic [1:0] w_c2;

  // ptr value 3 is unreachable; fold it onto 0 for safety
  assign w_c0 = (i_ptr == 2'd3) ? 2'd0 : i_ptr;
  assign w_c1 = nxt(w_c0);
  assign w_c2 = nxt(w_c1);

  assign o_found = |i_req;

  always_comb begin
    o_idx = SEL_D0;
    if (i_req[w_c0])      o_idx = w_c0;
    else if (i_req[w_c1]) o_idx = w_c1;
    else if (i_req[w_c2]) o_idx = w_c2;
  end

endmodule

// File: rtl/vec_mux_arbiter.sv
// Round-robin burst arbiter driving the 3:1 vector operand mux select.
// Ports: clk, reset, req[2:0], len0..2, out_ready -> out_valid, sel, gnt,
// beat_ack, last, busy. Macro VEC_ARB_PERF_EN adds gnt_cnt0..2 counters.
module vec_mux_arbiter
  import vec_arb_pkg::*;
#(
  parameter int LENW = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [LENW-1:0] len0,
  input  logic [LENW-1:0] len1,
  input  logic [LENW-1:0] len2,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [1:0]      sel,
  output logic [2:0]      gnt,
  output logic [2:0]      beat_ack,
  output logic            last,
  output logic            busy
`ifdef VEC_ARB_PERF_EN
  ,
  output logic [CNTW-1:0] gnt_cnt0,
  output logic [CNTW-1:0] gnt_cnt1,
  output logic [CNTW-1:0] gnt_cnt2
`endif
);

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  logic [1:0]      r_owner;
  logic [1:0]      w_owner_nxt;
  logic [1:0]      r_rr_ptr;
  logic [1:0]      w_rr_ptr_nxt;
  logic [LENW-1:0] r_len_q;
  logic [LENW-1:0] w_len_nxt;
  logic [LENW-1:0] r_beat_cnt;
  logic [LENW-1:0] w_cnt_nxt;

  logic [1:0]      w_idx;
  logic            w_found;
  logic            w_burst;
  logic            w_accept;
  logic            w_last;
  logic            w_grant;
  logic [LENW-1:0] w_len_sel;

  rr_pick3 u_pick (
    .i_req   (req),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  assign w_burst  = (r_state == ARB_BURST);
  assign w_accept = w_burst && out_ready;
  assign w_last   = w_burst && (r_beat_cnt == r_len_q);
  assign w_grant  = (r_state == ARB_IDLE) && w_found;

  always_comb begin
    w_len_sel = len0;
    case (w_idx)
      SEL_D1:  w_len_sel = len1;
      SEL_D2:  w_len_sel = len2;
      default: w_len_sel = len0;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    w_len_nxt    = r_len_q;
    w_cnt_nxt    = r_beat_cnt;
    case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_state_nxt  = ARB_BURST;
          w_owner_nxt  = w_idx;
          w_len_nxt    = w_len_sel;
          w_cnt_nxt    = '0;
          w_rr_ptr_nxt = (w_idx == 2'd2) ? 2'd0 : w_idx + 2'd1;
        end
      end
      ARB_BURST: begin
        if (w_accept) begin
          if (w_last) w_state_nxt = ARB_IDLE;
          else        w_cnt_nxt   = r_beat_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ARB_IDLE;
      r_owner    <= 2'd0;
      r_rr_ptr   <= 2'd0;
      r_len_q    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_len_q    <= w_len_nxt;
      r_beat_cnt <= w_cnt_nxt;
    end
  end

  assign out_valid = w_burst;
  assign busy      = w_burst;
  assign last      = w_last;
  assign sel       = w_burst ? r_owner : SEL_D0;
  assign gnt       = w_burst ? onehot3(r_owner) : 3'b000;
  // the beat is discarded when reset lands on it
  assign beat_ack  = (w_accept && !reset) ? onehot3(r_owner) : 3'b000;

`ifdef VEC_ARB_PERF_EN
  logic [CNTW-1:0] r_gnt_cnt [NREQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (reset) begin
        r_gnt_cnt[i] <= '0;
      end else if (w_grant && (w_idx == 2'(i)) &&
                   (r_gnt_cnt[i] != '1)) begin
        r_gnt_cnt[i] <= r_gnt_cnt[i] + 1'b1;
      end
    end
  end

  assign gnt_cnt0 = r_gnt_cnt[0];
  assign gnt_cnt1 = r_gnt_cnt[1];
  assign gnt_cnt2 = r_gnt_cnt[2];
`else
  logic w_unused;
  assign w_unused = w_grant & (CNTW > 0);
`endif

endmodule

// File: tb/tb_vec_mux_arbiter.sv
// Self-checking bench for vec_mux_arbiter: directed cases plus random
// traffic compared every cycle against a transaction-level model.
module tb_vec_mux_arbiter;

  localparam int LENW = 4;
  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [2:0]      req = 3'b000;
  logic [LENW-1:0] len0 = '0;
  logic [LENW-1:0] len1 = '0;
  logic [LENW-1:0] len2 = '0;
  logic            out_ready = 1'b0;
  logic            out_valid;
  logic [1:0]      sel;
  logic [2:0]      gnt;
  logic [2:0]      beat_ack;
  logic            last;
  logic            busy;
`ifdef VEC_ARB_PERF_EN
  logic [CNTW-1:0] gnt_cnt0, gnt_cnt1, gnt_cnt2;
`endif

  vec_mux_arbiter #(.LENW(LENW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .len0      (len0),
    .len1      (len1),
    .len2      (len2),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .sel       (sel),
    .gnt       (gnt),
    .beat_ack  (beat_ack),
    .last      (last),
    .busy      (busy)
`ifdef VEC_ARB_PERF_EN
    ,
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1),
    .gnt_cnt2  (gnt_cnt2)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an active burst is an owner plus beats remaining.
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_rem = 0;
  int m_ptr = 0;
  int m_cnt [3] = '{0, 0, 0};

  function automatic int len_of(input int i);
    if (i == 0) return int'(len0);
    if (i == 1) return int'(len1);
    return int'(len2);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      m_ptr = 0;
      m_owner = 0;
      m_rem = 0;
      m_cnt = '{0, 0, 0};
    end else if (!m_busy) begin
      int pick;
      pick = -1;
      for (int k = 0; k < 3; k++)
        if (pick < 0 && req[(m_ptr + k) % 3]) pick = (m_ptr + k) % 3;
      if (pick >= 0) begin
        m_owner = pick;
        m_rem = len_of(pick) + 1;
        m_ptr = (pick + 1) % 3;
        m_busy = 1'b1;
        if (m_cnt[pick] < (1 << CNTW) - 1) m_cnt[pick]++;
      end
    end else if (out_ready) begin
      m_rem--;
      if (m_rem == 0) m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [10:0] exp_v, act_v;
      logic [2:0]  oh;
      oh = m_busy ? 3'(1 << m_owner) : 3'b000;
      exp_v = {m_busy, m_busy ? 2'(m_owner) : 2'b00, oh,
               (out_ready && !reset) ? oh : 3'b000,
               m_busy && (m_rem == 1), m_busy};
      act_v = {out_valid, sel, gnt, beat_ack, last, busy};
      check("cycle{ov,sel,gnt,ack,last,busy}", 32'(act_v), 32'(exp_v));
`ifdef VEC_ARB_PERF_EN
      check("gnt_cnt0", 32'(gnt_cnt0), 32'(m_cnt[0]));
      check("gnt_cnt1", 32'(gnt_cnt1), 32'(m_cnt[1]));
      check("gnt_cnt2", 32'(gnt_cnt2), 32'(m_cnt[2]));
`endif
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int exp_sel [5] = '{0, 1, 2, 0, 1};
  bit rdy_seq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int acc;
    tick;
    chk_en = 1'b1;
    check("reset_outputs", 32'({out_valid, sel, gnt, beat_ack, last, busy}), 0);

    // single requester, 3-beat burst
    reset = 1'b0; req = 3'b001; len0 = 4'd2; out_ready = 1'b1;
    tick;
    check("t1_grant{gnt,sel,ov}", 32'({gnt, sel, out_valid}), 32'b001_00_1);
    check("t1_b1{ack,last}", 32'({beat_ack, last}), 32'b001_0);
    req = 3'b000;
    tick;
    check("t1_b2{ack,last}", 32'({beat_ack, last}), 32'b001_0);
    tick;
    check("t1_b3{ack,last}", 32'({beat_ack, last}), 32'b001_1);
    tick;
    check("t1_idle{ov,gnt}", 32'({out_valid, gnt}), 32'b0_000);

    // all requesting, single-beat bursts rotate with a bubble between
    reset = 1'b1; tick; reset = 1'b0;
    req = 3'b111; len0 = 0; len1 = 0; len2 = 0;
    for (int g = 0; g < 5; g++) begin
      tick;
      check("t2_sel", 32'(sel), 32'(exp_sel[g]));
      check("t2_last_ov", 32'({last, out_valid}), 32'b11);
      tick;
      check("t2_bubble", 32'(out_valid), 32'd0);
    end
    req = 3'b000;

    // backpressure; req drop and len change mid-burst ignored
    reset = 1'b1; tick; reset = 1'b0;
    req = 3'b010; len1 = 4'd3;
    tick;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      out_ready = rdy_seq[k];
      if (k == 1) begin req = 3'b000; len1 = 4'd0; end
      #1;
      check("t3_ack", 32'(beat_ack), rdy_seq[k] ? 32'b010 : 32'b000);
      check("t3_sel", 32'(sel), 32'b01);
      check("t3_last", 32'(last), (acc == 3) ? 32'd1 : 32'd0);
      if (rdy_seq[k]) acc++;
      tick;
    end
    check("t3_idle", 32'(out_valid), 32'd0);

    // reset on 2nd beat of a 4-beat burst
    reset = 1'b1; tick; reset = 1'b0;
    req = 3'b001; len0 = 4'd3; out_ready = 1'b1;
    tick;
    tick;
    reset = 1'b1; req = 3'b100;
    #1;
    check("t4_ack_in_reset", 32'(beat_ack), 32'd0);
    tick;
    check("t4_after_reset", 32'({out_valid, gnt, sel}), 32'd0);
    reset = 1'b0;
    tick;
    check("t4_regrant{gnt,sel}", 32'({gnt, sel}), 32'b100_10);
    req = 3'b000;

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      req = 3'($urandom_range(0, 7));
      len0 = LENW'($urandom);
      len1 = LENW'($urandom);
      len2 = LENW'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      reset = ($urandom_range(0, 299) == 0);
      tick;
    end
    reset = 1'b0;
    tick;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
